// File: rtl/ram_64x64_pkg.sv
// ram_pkg: shared widths and types for the 64x64 scratch RAM.
// Exports RAM_DATA_W, RAM_ADDR_W, RAM_DEPTH, ram_word_t, ram_addr_t.
package ram_pkg;

    localparam int RAM_DATA_W = 64;
    localparam int RAM_ADDR_W = 6;
    localparam int RAM_DEPTH  = 2 ** RAM_ADDR_W;

    typedef logic [RAM_DATA_W-1:0] ram_word_t;
    typedef logic [RAM_ADDR_W-1:0] ram_addr_t;

endpackage

// File: rtl/ram_64x64_if.sv
// ram_64x64_if: access bundle for the scratch RAM (strobes, addr, data).
// Ports: clk in; master drives w/r/addr/data_in, slave drives data_out.
interface ram_64x64_if
    import ram_pkg::*;
#(
    parameter int DATA_W = RAM_DATA_W,
    parameter int ADDR_W = RAM_ADDR_W
) (
    input logic clk
);

    logic              w;
    logic              r;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;

    modport master (
        input  clk,
        output w,
        output r,
        output addr,
        output data_in,
        input  data_out
    );

    modport slave (
        input  clk,
        input  w,
        input  r,
        input  addr,
        input  data_in,
        output data_out
    );

endinterface

// File: rtl/ram_64x64.sv
// ram_64x64: single-port synchronous RAM, flop array, registered read.
// Ports (positional order): w, r, clk, rst, addr, data_in, data_out.
module ram_64x64
    import ram_pkg::*;
#(
    parameter int DATA_W = RAM_DATA_W,
    parameter int ADDR_W = RAM_ADDR_W
) (
    input  logic              w,
    input  logic              r,
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Flop array (not block RAM) so every word can clear on reset.
    logic [DATA_W-1:0] mem [DEPTH];

    // Read samples mem before this edge's write lands, which gives
    // read-before-write on a simultaneous w/r at the same address.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            data_out <= '0;
        end else begin
            if (w) begin
                mem[addr] <= data_in;
            end
            if (r) begin
                data_out <= mem[addr];
            end
        end
    end

endmodule

// File: tb/tb_ram_64x64.sv
// tb_ram_64x64: directed self-checking bench for ram_64x64.
// Drives on negedge, samples 1ns after posedge.
module tb_ram_64x64;
    import ram_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ram_64x64_if #(.DATA_W(RAM_DATA_W), .ADDR_W(RAM_ADDR_W)) bus (.clk(clk));

    ram_64x64 dut (
        .w        (bus.w),
        .r        (bus.r),
        .clk      (clk),
        .rst      (rst),
        .addr     (bus.addr),
        .data_in  (bus.data_in),
        .data_out (bus.data_out)
    );

    task automatic cyc(input logic rs, input logic wv, input logic rv,
                       input ram_addr_t a, input ram_word_t d);
        @(negedge clk);
        rst         = rs;
        bus.w       = wv;
        bus.r       = rv;
        bus.addr    = a;
        bus.data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < RAM_DEPTH; i++) begin
            cyc(0, 1, 0, ram_addr_t'(i), 64'hA5A5_0000_0000_0000 | 64'(i + 1));
        end
        cyc(0, 0, 1, 6'd31, '0);
        checks++;
        if (bus.data_out !== 64'hA5A5_0000_0000_0020) begin
            errors++;
            $display("FAIL preload_31 got=%h exp=%h", bus.data_out,
                     64'hA5A5_0000_0000_0020);
        end
        cyc(1, 0, 0, '0, '0);
        cyc(1, 0, 0, '0, '0);
        checks++;
        if (bus.data_out !== 64'd0) begin
            errors++;
            $display("FAIL reset_dout got=%h exp=0", bus.data_out);
        end
        cyc(0, 0, 0, '0, '0);
        checks++;
        if (bus.data_out !== 64'd0) begin
            errors++;
            $display("FAIL post_reset_dout got=%h exp=0", bus.data_out);
        end
        cyc(0, 0, 1, 6'd0, '0);
        checks++;
        if (bus.data_out !== 64'd0) begin
            errors++;
            $display("FAIL reset_addr0 got=%h exp=0", bus.data_out);
        end
        cyc(0, 0, 1, 6'd31, '0);
        checks++;
        if (bus.data_out !== 64'd0) begin
            errors++;
            $display("FAIL reset_addr31 got=%h exp=0", bus.data_out);
        end
        cyc(0, 0, 1, 6'd63, '0);
        checks++;
        if (bus.data_out !== 64'd0) begin
            errors++;
            $display("FAIL reset_addr63 got=%h exp=0", bus.data_out);
        end
    endtask

    task automatic test_write_read();
        ram_word_t exp_v;
        for (int i = 1; i <= 5; i++) begin
            exp_v = 64'(i * 10);
            cyc(0, 1, 0, ram_addr_t'(i), exp_v);
            cyc(0, 0, 1, ram_addr_t'(i), '0);
            checks++;
            if (bus.data_out !== exp_v) begin
                errors++;
                $display("FAIL wr_rd_addr%0d got=%0d exp=%0d", i,
                         bus.data_out, exp_v);
            end
        end
    endtask

    task automatic test_hold();
        cyc(0, 0, 1, 6'd3, '0);
        checks++;
        if (bus.data_out !== 64'd30) begin
            errors++;
            $display("FAIL hold_read got=%0d exp=30", bus.data_out);
        end
        cyc(0, 0, 0, 6'd9, 64'd1234);
        cyc(0, 0, 0, 6'd1, 64'hDEAD);
        cyc(0, 0, 0, 6'd62, 64'hBEEF);
        checks++;
        if (bus.data_out !== 64'd30) begin
            errors++;
            $display("FAIL hold_idle got=%0d exp=30", bus.data_out);
        end
        cyc(0, 0, 1, 6'd3, '0);
        checks++;
        if (bus.data_out !== 64'd30) begin
            errors++;
            $display("FAIL hold_reread got=%0d exp=30", bus.data_out);
        end
        cyc(0, 0, 1, 6'd1, '0);
        checks++;
        if (bus.data_out !== 64'd10) begin
            errors++;
            $display("FAIL hold_addr1 got=%0d exp=10", bus.data_out);
        end
    endtask

    task automatic test_rw_same();
        cyc(0, 1, 1, 6'd2, 64'd99);
        checks++;
        if (bus.data_out !== 64'd20) begin
            errors++;
            $display("FAIL rbw_old got=%0d exp=20", bus.data_out);
        end
        cyc(0, 0, 1, 6'd2, '0);
        checks++;
        if (bus.data_out !== 64'd99) begin
            errors++;
            $display("FAIL rbw_new got=%0d exp=99", bus.data_out);
        end
    endtask

    task automatic test_boundary();
        cyc(0, 1, 0, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF);
        cyc(0, 1, 0, 6'd0, 64'h8000_0000_0000_0001);
        cyc(0, 0, 1, 6'd63, '0);
        checks++;
        if (bus.data_out !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("FAIL bnd_63 got=%h exp=ffffffffffffffff", bus.data_out);
        end
        cyc(0, 0, 1, 6'd0, '0);
        checks++;
        if (bus.data_out !== 64'h8000_0000_0000_0001) begin
            errors++;
            $display("FAIL bnd_0 got=%h exp=8000000000000001", bus.data_out);
        end
        cyc(0, 0, 1, 6'd62, '0);
        checks++;
        if (bus.data_out !== 64'd0) begin
            errors++;
            $display("FAIL bnd_62 got=%h exp=0", bus.data_out);
        end
        cyc(0, 0, 1, 6'd1, '0);
        checks++;
        if (bus.data_out !== 64'd10) begin
            errors++;
            $display("FAIL bnd_1 got=%0d exp=10", bus.data_out);
        end
    endtask

    task automatic test_reset_mid();
        cyc(0, 1, 0, 6'd8, 64'd55);
        cyc(0, 0, 1, 6'd8, '0);
        checks++;
        if (bus.data_out !== 64'd55) begin
            errors++;
            $display("FAIL mid_pre got=%0d exp=55", bus.data_out);
        end
        cyc(1, 1, 1, 6'd7, 64'd77);
        checks++;
        if (bus.data_out !== 64'd0) begin
            errors++;
            $display("FAIL mid_dout got=%0d exp=0", bus.data_out);
        end
        cyc(0, 0, 1, 6'd7, '0);
        checks++;
        if (bus.data_out !== 64'd0) begin
            errors++;
            $display("FAIL mid_addr7 got=%0d exp=0", bus.data_out);
        end
        cyc(0, 0, 1, 6'd8, '0);
        checks++;
        if (bus.data_out !== 64'd0) begin
            errors++;
            $display("FAIL mid_addr8 got=%0d exp=0", bus.data_out);
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.w       = 1'b0;
        bus.r       = 1'b0;
        bus.addr    = '0;
        bus.data_in = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_write_read();
        test_hold();
        test_rw_same();
        test_boundary();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_64x64.md
Name: ram_64x64

Overview:
- Single-port synchronous RAM, 64 words x 64 bits, with separate write and read strobes and a registered read-data output.
- General-purpose scratch storage for datapath blocks.
- Synchronous reset clears every storage word and the output register.
- Positional port order: w, r, clk, rst, addr, data_in, data_out. Existing instantiations connect by position, so this order is mandatory.

Parameters:
- DATA_W, 64, word width in bits.
- ADDR_W, 6, address width in bits.
- DEPTH, 2**ADDR_W (64), number of words. Derived; not to be overridden independently.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- w  input  1  write strobe; sampled at the rising edge.
- r  input  1  read strobe; sampled at the rising edge.
- addr  input  ADDR_W  word address, shared by read and write.
- data_in  input  DATA_W  write data.
- data_out  output  DATA_W  registered read data.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- All behaviour below is evaluated on the rising edge of clk.
- Reset (rst=1):
  - All DEPTH words are cleared to 0.
  - data_out is cleared to 0.
  - w and r are ignored that cycle.
  - Reset mid-operation discards any pending write or read in that cycle.
- Write (rst=0, w=1): mem[addr] <= data_in. Visible to a read issued on any later edge.
- Read (rst=0, r=1): data_out <= mem[addr]. data_out is valid after the same edge, i.e. one-cycle latency from the sampling edge.
- No read (r=0): data_out holds its previous value and never returns to 0 except on reset.
- Simultaneous w=1 and r=1 (rst=0):
  - Both take effect.
  - The read returns the pre-write contents (read-before-write).
  - The new data appears on a later read.
- Neither strobe: no state change.
- Address range: addr spans exactly DEPTH words, so there is no out-of-range case and no wrap logic.
- No handshake or ready signal: every access completes in one cycle, back-to-back, with no stall.
- Inputs are assumed stable around the rising edge. No internal X-propagation or clearing logic is needed beyond reset.
- Memory is a flop array, because clear-on-reset is required. Must not be inferred as a reset-less block RAM.

Decomposition:
- Package ram_pkg holds:
  - constants RAM_DATA_W=64 and RAM_ADDR_W=6;
  - RAM_DEPTH derived from RAM_ADDR_W;
  - typedefs ram_word_t (logic [RAM_DATA_W-1:0]) and ram_addr_t (logic [RAM_ADDR_W-1:0]).
- The module uses the package constants as parameter defaults.
- No sub-module: storage array, write logic and output register all live in ram_64x64.

Test Plan:
1. Reset clears everything: assert rst for 2 edges after preloading words 0..63 with nonzero data. Then read addr 0, 31 and 63 -> data_out=0 each time, and data_out=0 immediately after reset.
2. Write-then-read sequence: write 10,20,30,40,50 to addr 1..5 on alternating cycles, each followed by r=1 at the same addr -> data_out = 10,20,30,40,50 one edge after each read strobe.
3. Hold behaviour: read addr 3 (value 30), then idle (w=0, r=0) while addr and data_in change -> data_out stays 30. Stored data is unchanged; confirm by re-reading addr 3 -> 30.
4. Simultaneous read/write: addr 2 holds 20; assert w=1, r=1, data_in=99 -> data_out=20 after that edge. The next read of addr 2 -> 99.
5. Boundary addresses and full width:
   - write 64'hFFFF_FFFF_FFFF_FFFF to addr 63 and 64'h8000_0000_0000_0001 to addr 0;
   - read both back -> exact values;
   - addr 62 and addr 1 are unaffected.
6. Reset mid-operation: assert rst=1 together with w=1, addr=7, data_in=77 -> no write occurs and data_out=0. After reset, reading addr 7 -> 0.
